xz_input_conditioner: RTL and testbench

Two-channel input conditioner that sits directly upstream of the x/z Moore sequence FSM. It synchronizes and debounces the raw asynchronous `x_raw`/`z_raw` lines into clean, glitch-free levels `x`/`z` that the FSM samples. It also produces one-cycle change strobes so downstream logic or a bench can count accepted transitions.

---
 rtl/xz_cond_pkg.sv | 15 +
 rtl/xz_input_conditioner_debounce_ch.sv | 95 +++++++++
 rtl/xz_input_conditioner.sv | 53 +++++
 tb/tb_xz_input_conditioner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xz_cond_pkg.sv
// Shared definitions for the x/z input conditioner.
//   db_state_e          : per-channel debounce FSM state
//   SYNC_STAGES_DEF     : default synchronizer depth
//   DEBOUNCE_CYCLES_DEF : default number of qualifying samples
package xz_cond_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } db_state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/xz_input_conditioner_debounce_ch.sv
// One conditioner channel: synchronizer chain, debounce FSM with counter,
// registered output level and registered one-cycle change strobe.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   raw_i  : raw asynchronous input
//   lvl_o  : debounced, registered level
//   chg_o  : one-cycle pulse concurrent with a new lvl_o value
module debounce_ch
  import xz_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic chg_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   chg_q, chg_d;

  // Synchronizer: stage 0 captures the raw line, last stage is the clean sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      chg_q   <= chg_d;
    end
  end

  // cnt counts consecutive samples disagreeing with the output; any agreeing
  // sample drops back to STABLE so a bounce restarts qualification from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    chg_d   = 1'b0;
    case (state_q)
      STABLE: begin
        if (s != lvl_q) begin
          state_d = CHECK;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK: begin
        if (s == lvl_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          lvl_d   = s;
          chg_d   = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign lvl_o = lvl_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/xz_input_conditioner.sv
// Two-channel synchronizer/debouncer ahead of the x/z sequence FSM.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   x_raw, z_raw : raw asynchronous inputs
//   x, z         : debounced registered levels
//   x_chg, z_chg : one-cycle strobes concurrent with a new x / z value
module xz_input_conditioner
  import xz_cond_pkg::*;
#(
  parameter  int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic x_raw,
  input  logic z_raw,
  output logic x,
  output logic z,
  output logic x_chg,
  output logic z_chg
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_chk
    $error("xz_input_conditioner: SYNC_STAGES and DEBOUNCE_CYCLES must be >= 2");
  end

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_x_ch (
    .clk  (clk),
    .rst  (rst),
    .raw_i(x_raw),
    .lvl_o(x),
    .chg_o(x_chg)
  );

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_z_ch (
    .clk  (clk),
    .rst  (rst),
    .raw_i(z_raw),
    .lvl_o(z),
    .chg_o(z_chg)
  );

endmodule

// File: tb/tb_xz_input_conditioner.sv
// Bench for xz_input_conditioner with default parameters: a run-length
// reference model checked every cycle, plus directed literal expectations.
module tb_xz_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rst;
  logic x_raw, z_raw;
  logic x, z, x_chg, z_chg;

  int checks   = 0;
  int failures = 0;
  int nx_chg   = 0;
  int nz_chg   = 0;

  always #5 clk = ~clk;

  xz_input_conditioner dut (
    .clk  (clk),
    .rst  (rst),
    .x_raw(x_raw),
    .z_raw(z_raw),
    .x    (x),
    .z    (z),
    .x_chg(x_chg),
    .z_chg(z_chg)
  );

  // Reference model: raw samples are delayed SYNC edges, then the output
  // follows once DEB consecutive delayed samples disagree with it.
  bit m_dly [2][SYNC];
  int m_run [2];
  bit m_o   [2];
  bit m_chg [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < SYNC; i++) m_dly[c][i] = 1'b0;
        m_run[c] = 0;
        m_o[c]   = 1'b0;
        m_chg[c] = 1'b0;
      end
    end else begin
      bit r [2];
      r[0] = x_raw;
      r[1] = z_raw;
      for (int c = 0; c < 2; c++) begin
        bit s;
        s = m_dly[c][SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_dly[c][i] = m_dly[c][i-1];
        m_dly[c][0] = r[c];
        m_chg[c] = 1'b0;
        if (s != m_o[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_o[c]   = s;
            m_chg[c] = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_x", x, m_o[0]);
    chk("model_z", z, m_o[1]);
    chk("model_x_chg", x_chg, m_chg[0]);
    chk("model_z_chg", z_chg, m_chg[1]);
    if (x_chg === 1'b1) nx_chg++;
    if (z_chg === 1'b1) nz_chg++;
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  initial begin
    rst   = 1'b1;
    x_raw = 1'b1;
    z_raw = 1'b1;
    #1;
    chk("rst_x", x, 1'b0);
    chk("rst_z", z, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("rst_hold_x", x, 1'b0);
      chk("rst_hold_z", z, 1'b0);
      chk("rst_hold_xchg", x_chg, 1'b0);
      chk("rst_hold_zchg", z_chg, 1'b0);
    end
    rst = 1'b0;
    nx_chg = 0;
    nz_chg = 0;
    // Raw high at release: normal 0->1 with full latency.
    edges(5);
    chk("rel_x_e5", x, 1'b0);
    chk("rel_z_e5", z, 1'b0);
    edge1();
    chk("rel_x_e6", x, 1'b1);
    chk("rel_z_e6", z, 1'b1);
    chk("rel_xchg_e6", x_chg, 1'b1);
    chk("rel_zchg_e6", z_chg, 1'b1);
    edge1();
    chk("rel_xchg_e7", x_chg, 1'b0);
    chk_int("rel_nx", nx_chg, 1);
    chk_int("rel_nz", nz_chg, 1);

    // Settle both low.
    x_raw = 1'b0;
    z_raw = 1'b0;
    edges(10);
    chk("settle_x", x, 1'b0);
    chk("settle_z", z, 1'b0);

    // Clean step on x.
    nz_chg = 0;
    x_raw = 1'b1;
    edges(5);
    chk("step_x_e5", x, 1'b0);
    edge1();
    chk("step_x_e6", x, 1'b1);
    chk("step_xchg_e6", x_chg, 1'b1);
    chk("step_z", z, 1'b0);
    chk("step_zchg", z_chg, 1'b0);
    edge1();
    chk("step_xchg_e7", x_chg, 1'b0);
    edges(4);

    // Glitch: 3-cycle pulse rejected.
    z_raw = 1'b1;
    edges(3);
    z_raw = 1'b0;
    edges(10);
    chk("glitch3_z", z, 1'b0);
    chk_int("glitch3_nz", nz_chg, 0);
    // 4-cycle pulse accepted, then falls back.
    z_raw = 1'b1;
    edges(4);
    z_raw = 1'b0;
    edges(12);
    chk("glitch4_z", z, 1'b0);
    chk_int("glitch4_nz", nz_chg, 2);

    // Bounce on x: first drop x to 0.
    x_raw = 1'b0;
    edges(10);
    chk("bounce_pre_x", x, 1'b0);
    nx_chg = 0;
    begin
      logic [8:0] pat;
      pat = 9'b111101101;  // applied LSB first: 1,0,1,1,0,1,1,1,1
      for (int i = 0; i < 9; i++) begin
        x_raw = pat[i];
        edge1();
      end
    end
    x_raw = 1'b1;
    edge1();
    chk("bounce_x_e10", x, 1'b0);
    edge1();
    chk("bounce_x_e11", x, 1'b1);
    chk("bounce_xchg_e11", x_chg, 1'b1);
    edges(5);
    chk_int("bounce_nx", nx_chg, 1);

    // Simultaneous change.
    x_raw = 1'b0;
    z_raw = 1'b0;
    edges(10);
    x_raw = 1'b1;
    z_raw = 1'b1;
    edges(5);
    chk("sim_x_e5", x, 1'b0);
    chk("sim_z_e5", z, 1'b0);
    edge1();
    chk("sim_x_e6", x, 1'b1);
    chk("sim_z_e6", z, 1'b1);
    chk("sim_xchg", x_chg, 1'b1);
    chk("sim_zchg", z_chg, 1'b1);
    edges(5);

    // Reset two cycles into CHECK for x (x at 1, qualifying a fall).
    nx_chg = 0;
    x_raw = 1'b0;
    edges(4);
    chk("midrst_pre_x", x, 1'b1);
    rst   = 1'b1;
    x_raw = 1'b1;
    #1;
    chk("midrst_x", x, 1'b0);
    chk("midrst_xchg", x_chg, 1'b0);
    edges(2);
    rst = 1'b0;
    edges(5);
    chk("midrst_x_e5", x, 1'b0);
    chk_int("midrst_nx", nx_chg, 0);
    edge1();
    chk("midrst_x_e6", x, 1'b1);
    chk("midrst_xchg_e6", x_chg, 1'b1);
    edges(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
